// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 subset pipeline: op_type codes,
// opcode/funct encodings, pipeline register layouts and the decoder.
package mips32_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_J   = 4'd9;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // An all-zero IF/ID word decodes to OP_NOP, so '0 is a bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        wr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [25:0] jaddr;
    } idex_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  dst;
        logic        wr;
        logic [31:0] result;
        logic [31:0] sdata;
    } exmem_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  dst;
        logic        wr;
        logic [31:0] wdata;
    } memwb_t;

    // Unsupported encodings collapse to OP_NOP and behave as bubbles.
    function automatic logic [3:0] decode_op(input logic [31:0] instr);
        logic [3:0] op;
        op = OP_NOP;
        case (instr[31:26])
            OPC_RTYPE: begin
                case (instr[5:0])
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_SLT:  op = OP_SLT;
                    default: op = OP_NOP;
                endcase
            end
            OPC_LW:  op = OP_LW;
            OPC_SW:  op = OP_SW;
            OPC_BEQ: op = OP_BEQ;
            OPC_J:   op = OP_J;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips32_if.sv
// Instruction-fetch bus: the core drives the byte address, the external
// combinational instruction memory answers in the same cycle.
interface mips32_if;
    logic [31:0] inst_address;
    logic [31:0] instruction;

    modport master (output inst_address, input instruction);
    modport slave  (input inst_address, output instruction);
endinterface

// File: rtl/mips32_regfile.sv
// 32x32 register file, $0 reads as zero, WB write bypassed to same-cycle reads.
module mips32_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] r_regs [32];

    // Register write at the edge ending WB; $0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (i_we && i_wa != 5'd0) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports with write-through so WB and ID can overlap in one cycle.
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        o_rd2 = r_regs[i_ra2];
        if (i_we && i_wa == i_ra1) o_rd1 = i_wd;
        if (i_we && i_wa == i_ra2) o_rd2 = i_wd;
        if (i_ra1 == 5'd0) o_rd1 = 32'd0;
        if (i_ra2 == 5'd0) o_rd2 = 32'd0;
    end
endmodule

// File: rtl/mips32_cpu_top.sv
// Five-stage MIPS32 subset core: forwarding, load-use stall, branch/jump
// resolution in EX with a two-slot flush, internal 32-word data memory.
module mips32_cpu_top
    import mips32_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,     // active-high despite the name
    mips32_if.master imem,
    input  logic     test_se,
    input  logic     test_si,
    output logic     test_so
);
    logic [31:0] r_pc;
    ifid_t       r_ifid;
    idex_t       r_idex, w_idex_nxt;
    exmem_t      r_exmem;
    memwb_t      r_memwb;
    logic [31:0] r_dmem [32];

    logic [3:0]  op_type_ID, op_type_EX, op_type_MEM, op_type_WB;
    logic        stall, flush;

    logic [4:0]  w_rs, w_rt, w_rd, w_id_dst;
    logic        w_uses_rs, w_uses_rt, w_id_wr;
    logic [31:0] w_rs_val, w_rt_val;
    logic [31:0] w_op_a, w_op_b, w_alu, w_pc4_ex, w_target;
    logic [31:0] w_mem_rdata, w_wb_data;
    logic        w_unused;

    assign imem.inst_address = r_pc;
    assign test_so  = 1'b0;
    assign w_unused = ^{test_se, test_si, r_idex.imm[31:30]};

    assign op_type_ID  = decode_op(r_ifid.instr);
    assign op_type_EX  = r_idex.op;
    assign op_type_MEM = r_exmem.op;
    assign op_type_WB  = r_memwb.op;

    assign w_rs = r_ifid.instr[25:21];
    assign w_rt = r_ifid.instr[20:16];
    assign w_rd = r_ifid.instr[15:11];

    // ID: which source registers are really read, and the destination.
    always_comb begin
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_id_dst  = 5'd0;
        w_id_wr   = 1'b0;
        case (op_type_ID)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                w_uses_rs = 1'b1; w_uses_rt = 1'b1; w_id_dst = w_rd; w_id_wr = 1'b1;
            end
            OP_LW:  begin w_uses_rs = 1'b1; w_id_dst = w_rt; w_id_wr = 1'b1; end
            OP_SW, OP_BEQ: begin w_uses_rs = 1'b1; w_uses_rt = 1'b1; end
            default: ;
        endcase
    end

    mips32_regfile u_rf (
        .clk   (clk),
        .rst   (rst_n),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_we  (r_memwb.wr),
        .i_wa  (r_memwb.dst),
        .i_wd  (r_memwb.wdata),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val)
    );

    // Load-use: a LW in EX cannot forward its data until it reaches WB.
    assign stall = (r_idex.op == OP_LW) && (r_idex.dst != 5'd0) &&
                   ((w_uses_rs && w_rs == r_idex.dst) || (w_uses_rt && w_rt == r_idex.dst));

    // ID/EX payload assembled from the decoded IF/ID word.
    always_comb begin
        w_idex_nxt        = '0;
        w_idex_nxt.op     = op_type_ID;
        w_idex_nxt.pc     = r_ifid.pc;
        w_idex_nxt.rs     = w_rs;
        w_idex_nxt.rt     = w_rt;
        w_idex_nxt.dst    = w_id_dst;
        w_idex_nxt.wr     = w_id_wr;
        w_idex_nxt.rs_val = w_rs_val;
        w_idex_nxt.rt_val = w_rt_val;
        w_idex_nxt.imm    = {{16{r_ifid.instr[15]}}, r_ifid.instr[15:0]};
        w_idex_nxt.jaddr  = r_ifid.instr[25:0];
    end

    // EX operand forwarding: EX/MEM wins over MEM/WB; $0 never forwarded.
    always_comb begin
        w_op_a = r_idex.rs_val;
        w_op_b = r_idex.rt_val;
        if (r_idex.rs != 5'd0 && r_exmem.wr && r_exmem.dst == r_idex.rs)      w_op_a = r_exmem.result;
        else if (r_idex.rs != 5'd0 && r_memwb.wr && r_memwb.dst == r_idex.rs) w_op_a = r_memwb.wdata;
        if (r_idex.rt != 5'd0 && r_exmem.wr && r_exmem.dst == r_idex.rt)      w_op_b = r_exmem.result;
        else if (r_idex.rt != 5'd0 && r_memwb.wr && r_memwb.dst == r_idex.rt) w_op_b = r_memwb.wdata;
    end

    // ALU; loads and stores compute rs + sext(imm16).
    always_comb begin
        w_alu = 32'd0;
        case (r_idex.op)
            OP_ADD:       w_alu = w_op_a + w_op_b;
            OP_SUB:       w_alu = w_op_a - w_op_b;
            OP_AND:       w_alu = w_op_a & w_op_b;
            OP_OR:        w_alu = w_op_a | w_op_b;
            OP_SLT:       w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            OP_LW, OP_SW: w_alu = w_op_a + r_idex.imm;
            default:      w_alu = 32'd0;
        endcase
    end

    // J target keeps the raw 26-bit field as a byte address (no shift).
    assign w_pc4_ex = r_idex.pc + 32'd4;
    assign w_target = (r_idex.op == OP_J) ? {w_pc4_ex[31:26], r_idex.jaddr}
                                          : w_pc4_ex + {r_idex.imm[29:0], 2'b00};
    assign flush    = (r_idex.op == OP_J) || ((r_idex.op == OP_BEQ) && (w_op_a == w_op_b));

    assign w_mem_rdata = r_dmem[r_exmem.result[4:0]];
    assign w_wb_data   = (r_exmem.op == OP_LW) ? w_mem_rdata : r_exmem.result;

    // Pipeline advance; flush outranks stall.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pc    <= 32'd0;
            r_ifid  <= '0;
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            if (flush) begin
                r_pc   <= w_target;
                r_ifid <= '0;
                r_idex <= '0;
            end else if (stall) begin
                r_idex <= '0;
            end else begin
                r_pc   <= r_pc + 32'd4;
                r_ifid <= '{pc: r_pc, instr: imem.instruction};
                r_idex <= w_idex_nxt;
            end
            r_exmem <= '{op: r_idex.op, dst: r_idex.dst, wr: r_idex.wr, result: w_alu, sdata: w_op_b};
            r_memwb <= '{op: r_exmem.op, dst: r_exmem.dst, wr: r_exmem.wr, wdata: w_wb_data};
        end
    end

    // Data memory: word index from address[4:0], reset image mem[i] = i+1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) r_dmem[i] <= 32'(i + 1);
        end else if (r_exmem.op == OP_SW) begin
            r_dmem[r_exmem.result[4:0]] <= r_exmem.sdata;
        end
    end
endmodule

// File: tb/tb_mips32_cpu_top.sv
// Bench for mips32_cpu_top: per-cycle fetch/pipeline trace scoreboard on the
// reference program, then register/memory checks on a store/SLT program.
module tb_mips32_cpu_top;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic test_se = 1'b0;
    logic test_si = 1'b0;
    logic test_so;

    mips32_if imem_if ();
    logic [31:0] rom [64];
    assign imem_if.instruction = rom[imem_if.inst_address[7:2]];

    mips32_cpu_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .imem    (imem_if.master),
        .test_se (test_se),
        .test_si (test_si),
        .test_so (test_so)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] opc, input int rs, input int rt, input int imm);
        return {opc, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_ins(input int addr);
        return {6'h02, 26'(addr)};
    endfunction

    // Hand-derived trace of the reference program, one entry per cycle
    // after reset release: fetch address, op in ID, op in EX, stall, flush.
    localparam int NT = 22;
    localparam int T_PC [NT] = '{'h00,'h04,'h08,'h0C,'h0C,'h10,'h14,'h18,'h1C,'h20,'h24,
                                 'h28,'h18,'h1C,'h20,'h24,'h24,'h28,'h2C,'h24,'h28,'h2C};
    localparam int T_ID [NT] = '{0,6,6,1,1,1,3,4,2,8,9,9,0,2,8,9,0,9,0,0,9,0};
    localparam int T_EX [NT] = '{0,0,6,6,0,1,1,3,4,2,8,9,0,0,2,8,0,0,9,0,0,9};
    localparam int T_ST [NT] = '{0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    localparam int T_FL [NT] = '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,1,0,0,1,0,0,1};

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  id;
        logic [3:0]  ex;
        logic        st;
        logic        fl;
        int          cyc;
    } exp_t;

    exp_t sb_q [$];
    exp_t e_mon;
    exp_t e_in;

    // Monitor: one expected entry consumed per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e_mon = sb_q.pop_front();
            chk($sformatf("pc_c%0d", e_mon.cyc), imem_if.inst_address, e_mon.pc);
            chk($sformatf("opID_c%0d", e_mon.cyc), 32'(dut.op_type_ID), 32'(e_mon.id));
            chk($sformatf("opEX_c%0d", e_mon.cyc), 32'(dut.op_type_EX), 32'(e_mon.ex));
            chk($sformatf("stall_c%0d", e_mon.cyc), 32'(dut.stall), 32'(e_mon.st));
            chk($sformatf("flush_c%0d", e_mon.cyc), 32'(dut.flush), 32'(e_mon.fl));
        end
    end

    logic cnt_en = 1'b0;
    int   stall_cnt = 0;
    always @(negedge clk) if (cnt_en && dut.stall) stall_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        rom[0] = i_ins(6'h23, 0, 1, 0);        // lw  $1,0($0)
        rom[1] = i_ins(6'h23, 0, 2, 1);        // lw  $2,1($0)
        rom[2] = r_ins(6'h20, 3, 1, 2);        // add $3,$1,$2
        rom[3] = r_ins(6'h20, 4, 3, 0);        // add $4,$3,$0
        rom[4] = r_ins(6'h24, 5, 3, 2);        // and $5,$3,$2
        rom[5] = r_ins(6'h25, 6, 3, 2);        // or  $6,$3,$2
        rom[6] = r_ins(6'h22, 4, 4, 1);        // sub $4,$4,$1
        rom[7] = i_ins(6'h04, 4, 1, 1);        // beq $4,$1,1
        rom[8] = j_ins('h18);                  // j 0x18
        rom[9] = j_ins('h24);                  // j 0x24

        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pc", imem_if.inst_address, 32'd0);
        chk("rst_opID", 32'(dut.op_type_ID), 32'd0);
        chk("rst_opEX", 32'(dut.op_type_EX), 32'd0);
        chk("rst_opMEM", 32'(dut.op_type_MEM), 32'd0);
        chk("rst_opWB", 32'(dut.op_type_WB), 32'd0);
        chk("rst_stall", 32'(dut.stall), 32'd0);
        chk("rst_flush", 32'(dut.flush), 32'd0);
        chk("rst_test_so", 32'(test_so), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;

        for (int i = 0; i < NT; i++) begin
            e_in.pc  = 32'(T_PC[i]);
            e_in.id  = 4'(T_ID[i]);
            e_in.ex  = 4'(T_EX[i]);
            e_in.st  = T_ST[i] != 0;
            e_in.fl  = T_FL[i] != 0;
            e_in.cyc = i;
            sb_q.push_back(e_in);
        end
        repeat (NT + 2) @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        chk("p1_r1", dut.u_rf.r_regs[1], 32'd1);
        chk("p1_r2", dut.u_rf.r_regs[2], 32'd2);
        chk("p1_r3", dut.u_rf.r_regs[3], 32'd3);
        chk("p1_r4", dut.u_rf.r_regs[4], 32'd1);
        chk("p1_r5", dut.u_rf.r_regs[5], 32'd2);
        chk("p1_r6", dut.u_rf.r_regs[6], 32'd3);

        // Asynchronous reset in the middle of a cycle clears everything at once.
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rst_pc", imem_if.inst_address, 32'd0);
        chk("mid_rst_opEX", 32'(dut.op_type_EX), 32'd0);
        chk("mid_rst_opMEM", 32'(dut.op_type_MEM), 32'd0);
        chk("mid_rst_r3", dut.u_rf.r_regs[3], 32'd0);
        chk("mid_rst_r6", dut.u_rf.r_regs[6], 32'd0);
        chk("mid_rst_dmem4", dut.r_dmem[4], 32'd5);

        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        rom[0] = i_ins(6'h23, 0, 1, 0);        // lw  $1,0($0)
        rom[1] = i_ins(6'h23, 0, 2, 1);        // lw  $2,1($0)
        rom[2] = r_ins(6'h20, 3, 1, 2);        // add $3,$1,$2   (load-use)
        rom[3] = i_ins(6'h2B, 0, 3, 4);        // sw  $3,4($0)
        rom[4] = i_ins(6'h23, 0, 7, 4);        // lw  $7,4($0)
        rom[5] = r_ins(6'h2A, 8, 1, 2);        // slt $8,$1,$2
        rom[6] = r_ins(6'h2A, 9, 2, 1);        // slt $9,$2,$1
        rom[7] = r_ins(6'h22, 10, 0, 1);       // sub $10,$0,$1
        rom[8] = r_ins(6'h2A, 11, 10, 1);      // slt $11,$10,$1 (signed)
        rom[9] = j_ins('h24);                  // j 0x24

        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        stall_cnt = 0;
        cnt_en = 1'b1;
        repeat (40) @(negedge clk);
        #1 cnt_en = 1'b0;
        chk("p2_stalls", 32'(stall_cnt), 32'd1);
        chk("p2_r3", dut.u_rf.r_regs[3], 32'd3);
        chk("p2_r7", dut.u_rf.r_regs[7], 32'd3);
        chk("p2_r8", dut.u_rf.r_regs[8], 32'd1);
        chk("p2_r9", dut.u_rf.r_regs[9], 32'd0);
        chk("p2_r10", dut.u_rf.r_regs[10], 32'hFFFF_FFFF);
        chk("p2_r11", dut.u_rf.r_regs[11], 32'd1);
        chk("p2_r0", dut.u_rf.r_regs[0], 32'd0);
        chk("p2_dmem4", dut.r_dmem[4], 32'd3);
        chk("p2_dmem5", dut.r_dmem[5], 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
